// File: rtl/insight_dcache_txn_tracker.sv
// Passive tracker that pairs hart 0 commit-stage DCache request/response insight events
// by tag, times them, and streams completed records to one trace-sink channel.
module insight_dcache_txn_tracker #(
  parameter int TAG_W   = 6,
  parameter int ADDR_W  = 40,
  parameter int ENTRIES = 8,
  parameter int LAT_W   = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [TAG_W-1:0]           req_tag,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [4:0]                 req_cmd,
  input  logic                       resp_valid,
  input  logic [TAG_W-1:0]           resp_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_W-1:0]           out_tag,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [4:0]                 out_cmd,
  output logic [LAT_W-1:0]           out_latency,
  output logic                       out_timeout,
  output logic [$clog2(ENTRIES):0]   outstanding,
  output logic [15:0]                drop_count,
  output logic                       err_unmatched,
  output logic                       err_dup_tag
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [LAT_W-1:0] TMO_VAL = LAT_W'(TIMEOUT);

  typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_DONE} entry_state_e;

  entry_state_e       st_q   [ENTRIES];
  entry_state_e       st_d   [ENTRIES];
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [ADDR_W-1:0]  addr_q [ENTRIES];
  logic [4:0]         cmd_q  [ENTRIES];
  logic [LAT_W-1:0]   lat_q  [ENTRIES];
  logic               tmo_q  [ENTRIES];

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic [IDX_W-1:0]   alloc_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic [ENTRIES-1:0] match_vec;
  logic [ENTRIES-1:0] tmo_vec;
  logic               dup_hit;
  logic               free_found;
  logic               sel_found;
  logic               do_alloc;
  logic               do_drop;
  logic               handshake;
  logic [CNT_W-1:0]   busy_cnt;

  // All decisions look only at the table as it stood at the start of the cycle.
  always_comb begin
    match_vec  = '0;
    tmo_vec    = '0;
    dup_hit    = 1'b0;
    free_found = 1'b0;
    alloc_idx  = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    cand       = '0;
    busy_cnt   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (st_q[i] == ST_PEND) begin
        if (resp_valid && tag_q[i] == resp_tag) match_vec[i] = 1'b1;
        if (lat_q[i] == TMO_VAL)                tmo_vec[i]   = 1'b1;
        if (req_valid && tag_q[i] == req_tag)   dup_hit      = 1'b1;
      end
      if (st_q[i] != ST_FREE) busy_cnt = busy_cnt + CNT_W'(1);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (st_q[i] == ST_FREE) begin
        free_found = 1'b1;
        alloc_idx  = IDX_W'(i);
      end
    end
    // Round-robin search begins just after the last granted index.
    for (int k = 1; k <= ENTRIES; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!sel_found && st_q[cand] == ST_DONE) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    do_alloc  = req_valid && !dup_hit && free_found;
    do_drop   = req_valid && !do_alloc;
    handshake = out_valid && out_ready;
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        ST_FREE: if (do_alloc && alloc_idx == IDX_W'(i))   st_d[i] = ST_PEND;
        ST_PEND: if (match_vec[i] || tmo_vec[i])          st_d[i] = ST_DONE;
        ST_DONE: if (handshake && out_idx_q == IDX_W'(i)) st_d[i] = ST_FREE;
        default:                                          st_d[i] = ST_FREE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (reset) st_q[i] <= ST_FREE;
      else       st_q[i] <= st_d[i];
    end
  end

  // A response arriving on the timeout cycle wins but cannot push latency past TIMEOUT.
  always_ff @(posedge clock) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (reset) begin
        tag_q[i]  <= '0;
        addr_q[i] <= '0;
        cmd_q[i]  <= '0;
        lat_q[i]  <= '0;
        tmo_q[i]  <= 1'b0;
      end else if (st_q[i] == ST_FREE && st_d[i] == ST_PEND) begin
        tag_q[i]  <= req_tag;
        addr_q[i] <= req_addr;
        cmd_q[i]  <= req_cmd;
        lat_q[i]  <= '0;
        tmo_q[i]  <= 1'b0;
      end else if (st_q[i] == ST_PEND) begin
        if (match_vec[i]) begin
          lat_q[i] <= tmo_vec[i] ? TMO_VAL : lat_q[i] + LAT_W'(1);
          tmo_q[i] <= 1'b0;
        end else if (tmo_vec[i]) begin
          tmo_q[i] <= 1'b1;
        end else begin
          lat_q[i] <= lat_q[i] + LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_idx_q     <= '0;
      ptr_q         <= IDX_W'(ENTRIES - 1);
      out_tag       <= '0;
      out_addr      <= '0;
      out_cmd       <= '0;
      out_latency   <= '0;
      out_timeout   <= 1'b0;
      outstanding   <= '0;
      drop_count    <= '0;
      err_unmatched <= 1'b0;
      err_dup_tag   <= 1'b0;
    end else begin
      if (handshake) begin
        out_valid <= 1'b0;
        ptr_q     <= out_idx_q;
      end else if (!out_valid && sel_found) begin
        out_valid   <= 1'b1;
        out_idx_q   <= sel_idx;
        out_tag     <= tag_q[sel_idx];
        out_addr    <= addr_q[sel_idx];
        out_cmd     <= cmd_q[sel_idx];
        out_latency <= lat_q[sel_idx];
        out_timeout <= tmo_q[sel_idx];
      end
      outstanding <= busy_cnt;
      if (do_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (resp_valid && match_vec == '0)     err_unmatched <= 1'b1;
      if (req_valid && dup_hit)              err_dup_tag   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_insight_dcache_txn_tracker.sv
// Bench for insight_dcache_txn_tracker: timestamp-based transaction model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_insight_dcache_txn_tracker;

  localparam int TAG_W   = 6;
  localparam int ADDR_W  = 40;
  localparam int ENTRIES = 8;
  localparam int LAT_W   = 12;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = $clog2(ENTRIES) + 1;
  localparam int S_FREE = 0, S_PEND = 1, S_DONE = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [4:0]        req_cmd = '0;
  logic              resp_valid = 1'b0;
  logic [TAG_W-1:0]  resp_tag = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [TAG_W-1:0]  out_tag;
  logic [ADDR_W-1:0] out_addr;
  logic [4:0]        out_cmd;
  logic [LAT_W-1:0]  out_latency;
  logic              out_timeout;
  logic [CNT_W-1:0]  outstanding;
  logic [15:0]       drop_count;
  logic              err_unmatched;
  logic              err_dup_tag;

  insight_dcache_txn_tracker #(
    .TAG_W(TAG_W), .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_tag(req_tag), .req_addr(req_addr), .req_cmd(req_cmd),
    .resp_valid(resp_valid), .resp_tag(resp_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_addr(out_addr),
    .out_cmd(out_cmd), .out_latency(out_latency), .out_timeout(out_timeout),
    .outstanding(outstanding), .drop_count(drop_count),
    .err_unmatched(err_unmatched), .err_dup_tag(err_dup_tag)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: entries carry their allocation timestamp; latency is derived from elapsed cycles.
  int                m_st    [ENTRIES];
  logic [TAG_W-1:0]  m_tag   [ENTRIES];
  logic [ADDR_W-1:0] m_addr  [ENTRIES];
  logic [4:0]        m_cmd   [ENTRIES];
  int                m_alloc [ENTRIES];
  int                m_lat   [ENTRIES];
  bit                m_tmo   [ENTRIES];
  bit                m_ov;
  int                m_oidx, m_ptr;
  logic [TAG_W-1:0]  m_otag;
  logic [ADDR_W-1:0] m_oaddr;
  logic [4:0]        m_ocmd;
  int                m_olat;
  bit                m_otmo;
  int                m_outstanding, m_drop;
  bit                m_eu, m_ed;
  int                cyc = 0;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_st[i] = S_FREE; m_tag[i] = '0; m_addr[i] = '0; m_cmd[i] = '0;
      m_alloc[i] = 0; m_lat[i] = 0; m_tmo[i] = 1'b0;
    end
    m_ov = 1'b0; m_oidx = 0; m_ptr = ENTRIES - 1;
    m_otag = '0; m_oaddr = '0; m_ocmd = '0; m_olat = 0; m_otmo = 1'b0;
    m_outstanding = 0; m_drop = 0; m_eu = 1'b0; m_ed = 1'b0;
  endfunction

  function automatic void model_step();
    int  st0 [ENTRIES];
    int  found;
    int  busy;
    int  d;
    bit  dup;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    st0  = m_st;
    busy = 0;
    for (int i = 0; i < ENTRIES; i++) if (st0[i] != S_FREE) busy++;
    if (m_ov && out_ready) begin
      m_st[m_oidx] = S_FREE;
      m_ptr = m_oidx;
      m_ov  = 1'b0;
    end else if (!m_ov) begin
      for (int k = 1; k <= ENTRIES; k++) begin
        int c;
        c = (m_ptr + k) % ENTRIES;
        if (st0[c] == S_DONE) begin
          m_ov = 1'b1; m_oidx = c;
          m_otag = m_tag[c]; m_oaddr = m_addr[c]; m_ocmd = m_cmd[c];
          m_olat = m_lat[c]; m_otmo = m_tmo[c];
          break;
        end
      end
    end
    if (resp_valid) begin
      found = -1;
      for (int i = 0; i < ENTRIES; i++)
        if (st0[i] == S_PEND && m_tag[i] == resp_tag) found = i;
      if (found < 0) m_eu = 1'b1;
      else begin
        d = cyc - m_alloc[found];
        m_st[found]  = S_DONE;
        m_lat[found] = (d < TIMEOUT) ? d : TIMEOUT;
        m_tmo[found] = 1'b0;
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (st0[i] == S_PEND && m_st[i] == S_PEND && (cyc - 1 - m_alloc[i]) == TIMEOUT) begin
        m_st[i] = S_DONE; m_lat[i] = TIMEOUT; m_tmo[i] = 1'b1;
      end
    end
    if (req_valid) begin
      dup = 1'b0;
      found = -1;
      for (int i = 0; i < ENTRIES; i++)
        if (st0[i] == S_PEND && m_tag[i] == req_tag) dup = 1'b1;
      for (int i = ENTRIES - 1; i >= 0; i--)
        if (st0[i] == S_FREE) found = i;
      if (dup || found < 0) begin
        if (dup) m_ed = 1'b1;
        if (m_drop < 16'hFFFF) m_drop++;
      end else begin
        m_st[found] = S_PEND; m_tag[found] = req_tag; m_addr[found] = req_addr;
        m_cmd[found] = req_cmd; m_alloc[found] = cyc; m_lat[found] = 0; m_tmo[found] = 1'b0;
      end
    end
    m_outstanding = busy;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_output();
    cmp("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      cmp("out_tag",     64'(out_tag),     64'(m_otag));
      cmp("out_addr",    64'(out_addr),    64'(m_oaddr));
      cmp("out_cmd",     64'(out_cmd),     64'(m_ocmd));
      cmp("out_latency", 64'(out_latency), 64'(m_olat));
      cmp("out_timeout", 64'(out_timeout), 64'(m_otmo));
    end
    cmp("outstanding",   64'(outstanding),   64'(m_outstanding));
    cmp("drop_count",    64'(drop_count),    64'(m_drop));
    cmp("err_unmatched", 64'(err_unmatched), 64'(m_eu));
    cmp("err_dup_tag",   64'(err_dup_tag),   64'(m_ed));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_output();
  endtask

  task automatic idle();
    req_valid = 1'b0; resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
  endtask

  task automatic send_req(input int tag, input logic [ADDR_W-1:0] addr, input int cmd);
    req_valid = 1'b1; req_tag = TAG_W'(tag); req_addr = addr; req_cmd = 5'(cmd);
  endtask

  task automatic send_resp(input int tag);
    resp_valid = 1'b1; resp_tag = TAG_W'(tag);
  endtask

  task automatic wait_out_valid(input int budget, output int waited);
    waited = 0;
    idle();
    while (!out_valid && waited < budget) begin
      tick();
      waited++;
    end
    cmp("wait_out_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic apply_stimulus();
    logic [TAG_W-1:0] pend_tags[$];
    idle();
    reset     = ($urandom_range(0, 999) == 0);
    out_ready = ($urandom_range(0, 99) < 60);
    if ($urandom_range(0, 99) < 40)
      send_req($urandom_range(0, 15), {8'($urandom), $urandom}, $urandom_range(0, 31));
    if ($urandom_range(0, 99) < 35) begin
      for (int i = 0; i < ENTRIES; i++) if (m_st[i] == S_PEND) pend_tags.push_back(m_tag[i]);
      if (pend_tags.size() > 0 && $urandom_range(0, 3) != 0)
        send_resp(pend_tags[$urandom_range(0, pend_tags.size() - 1)]);
      else
        send_resp($urandom_range(0, 15));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    int tag8_seen;
    logic [TAG_W-1:0] grants[$];
    model_reset();

    // Reset values
    do_reset();
    cmp("reset_out_valid", 64'(out_valid), 64'd0);
    cmp("reset_out_tag", 64'(out_tag), 64'd0);
    cmp("reset_outstanding", 64'(outstanding), 64'd0);

    // Single transaction, latency 3
    out_ready = 1'b1;
    send_req(5, 40'h0080001000, 0); tick();
    idle(); tick(); tick();
    send_resp(5); tick();
    wait_out_valid(10, waited);
    cmp("single_tag", 64'(out_tag), 64'd5);
    cmp("single_addr", 64'(out_addr), 64'h80001000);
    cmp("single_latency", 64'(out_latency), 64'd3);
    cmp("single_timeout", 64'(out_timeout), 64'd0);
    repeat (3) tick();
    cmp("single_outstanding_zero", 64'(outstanding), 64'd0);

    // Overflow: nine requests into eight entries
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 9; t++) begin
      send_req(t, 40'h1000 + 40'(t), 1); tick();
    end
    idle(); tick();
    cmp("overflow_outstanding", 64'(outstanding), 64'd8);
    cmp("overflow_drop", 64'(drop_count), 64'd1);
    out_ready = 1'b1;
    tag8_seen = 0;
    for (int n = 0; n < 50; n++) begin
      if (out_valid && out_tag == TAG_W'(8)) tag8_seen++;
      tick();
    end
    cmp("overflow_tag8_absent", 64'(tag8_seen), 64'd0);

    // Round-robin order with backpressure
    do_reset();
    out_ready = 1'b0;
    for (int t = 10; t < 16; t++) begin
      send_req(t, 40'h2000 + 40'(t), 2); tick();
    end
    send_resp(10); tick();
    send_resp(12); tick();
    send_resp(15); tick();
    idle();
    for (int n = 0; n < 4; n++) begin
      tick();
      cmp("rr_hold_valid", 64'(out_valid), 64'd1);
      cmp("rr_hold_tag", 64'(out_tag), 64'd10);
    end
    out_ready = 1'b1;
    waited = 0;
    while (grants.size() < 3 && waited < 20) begin
      if (out_valid) grants.push_back(out_tag);
      tick();
      waited++;
    end
    cmp("rr_grant_count", 64'(grants.size()), 64'd3);
    if (grants.size() == 3) begin
      cmp("rr_grant0", 64'(grants[0]), 64'd10);
      cmp("rr_grant1", 64'(grants[1]), 64'd12);
      cmp("rr_grant2", 64'(grants[2]), 64'd15);
    end

    // Timeout forced completion, then a late response
    do_reset();
    out_ready = 1'b1;
    send_req(20, 40'h3000, 3); tick();
    wait_out_valid(40, waited);
    cmp("timeout_wait_ge16", 64'(waited >= 16), 64'd1);
    cmp("timeout_flag", 64'(out_timeout), 64'd1);
    cmp("timeout_latency", 64'(out_latency), 64'd15);
    tick();
    cmp("timeout_no_unmatched_yet", 64'(err_unmatched), 64'd0);
    send_resp(20); tick();
    idle(); tick();
    cmp("timeout_late_resp_unmatched", 64'(err_unmatched), 64'd1);

    // Same-cycle request and response, then duplicate tag
    do_reset();
    send_req(3, 40'h4000, 4); send_resp(3); tick();
    idle(); tick();
    cmp("samecyc_unmatched", 64'(err_unmatched), 64'd1);
    cmp("samecyc_outstanding", 64'(outstanding), 64'd1);
    cmp("samecyc_no_dup_yet", 64'(err_dup_tag), 64'd0);
    send_req(3, 40'h4004, 4); tick();
    idle(); tick();
    cmp("dup_flag", 64'(err_dup_tag), 64'd1);
    cmp("dup_drop", 64'(drop_count), 64'd1);

    // Reset while a record is presented and four entries are pending
    do_reset();
    out_ready = 1'b0;
    for (int t = 30; t < 35; t++) begin
      send_req(t, 40'h5000 + 40'(t), 5); tick();
    end
    send_resp(30); tick();
    send_resp(50); send_req(31, 40'h5100, 5); tick();
    idle(); tick(); tick();
    cmp("midreset_pre_valid", 64'(out_valid), 64'd1);
    cmp("midreset_pre_outstanding", 64'(outstanding), 64'd5);
    reset = 1'b1; tick();
    reset = 1'b0;
    cmp("midreset_valid", 64'(out_valid), 64'd0);
    cmp("midreset_outstanding", 64'(outstanding), 64'd0);
    cmp("midreset_drop", 64'(drop_count), 64'd0);
    cmp("midreset_flags", 64'({err_unmatched, err_dup_tag}), 64'd0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      apply_stimulus();
      tick();
    end
    idle(); reset = 1'b0; out_ready = 1'b1;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/insight_dcache_txn_tracker.md
Name: insight_dcache_txn_tracker

Overview:
- Passive tracker on hart 0's commit-stage DCache insight streams: request events and response events.
- Matches each response to its outstanding request by tag and measures request-to-response latency in cycles.
- Round-robin schedules completed transactions, including timed-out ones, onto one trace-sink channel with valid/ready backpressure.
- Observation only: never backpressures the core; lost events are counted, not stalled.

Parameters:
- TAG_W, 6: request/response tag width.
- ADDR_W, 40: physical address width.
- ENTRIES, 8: outstanding-transaction table depth (power of 2, ≥2).
- LAT_W, 12: latency counter width.
- TIMEOUT, 4095: latency value at which a pending entry is force-completed (must be < 2^LAT_W).

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  commit-stage DCache request observed this cycle.
- req_tag  in  TAG_W  request tag.
- req_addr  in  ADDR_W  request address.
- req_cmd  in  5  memory command code.
- resp_valid  in  1  DCache response observed this cycle.
- resp_tag  in  TAG_W  tag of the completed request.
- out_valid  out  1  completed-transaction record available.
- out_ready  in  1  trace sink accepts the record.
- out_tag  out  TAG_W  record tag.
- out_addr  out  ADDR_W  record address.
- out_cmd  out  5  record command.
- out_latency  out  LAT_W  cycles from request to response (or TIMEOUT).
- out_timeout  out  1  record was force-completed.
- outstanding  out  $clog2(ENTRIES)+1  entries not FREE.
- drop_count  out  16  saturating count of dropped requests.
- err_unmatched  out  1  sticky: a response matched no PEND entry.
- err_dup_tag  out  1  sticky: a request reused a tag already PEND.

Behaviour:
- Reset: all entries FREE; all outputs 0, counters 0, sticky flags 0. Reset mid-operation discards all entries and any presented record without a handshake.
- Entry states: FREE -> PEND (on allocation) -> DONE (on response or timeout) -> FREE (on output handshake).
- Allocation: on req_valid, take the lowest-index FREE entry. Store tag, addr and cmd; latency = 0; timeout flag = 0.
- Full table, or dup tag (req_tag equal to a PEND entry's tag): request dropped, drop_count += 1 saturating at 0xFFFF. Dup tag also sets err_dup_tag.
- Entry freed this cycle by handshake: not allocatable until the next cycle.
- Latency: each PEND entry increments by 1 per cycle, starting the cycle after allocation. Response in the cycle after the request records latency 1. DONE entries hold their latency.
- Response match: resp_valid compared only against entries PEND at the start of the cycle. An entry allocated in the same cycle is never matched, so a same-cycle req and resp with the same tag sets err_unmatched.
  - Match: entry -> DONE, latency value +1 captured.
  - No match: err_unmatched set.
  - Tags unique among PEND entries, so at most one match.
- Timeout: a PEND entry whose latency equals TIMEOUT -> DONE with timeout = 1, latency = TIMEOUT. A response in that same cycle takes priority: timeout = 0, latency = TIMEOUT.
- Output scheduler: registered selection.
  - With out_valid = 0 and ≥1 DONE entry, the next cycle presents a DONE entry chosen round-robin, starting after the last granted index (pointer resets to ENTRIES-1, so entry 0 is first).
  - out_* stay stable while out_valid && !out_ready.
  - Handshake: entry -> FREE and pointer = granted index. out_valid deasserts the following cycle; back-to-back records therefore take ≥2 cycles each.
- outstanding: registered count of non-FREE entries, updated the cycle after each event.

Test Plan:
- Single txn: req tag 5 addr 0x80001000 cmd 0 at T; resp tag 5 at T+3; out_ready = 1 -> one record: tag 5, latency 3, timeout 0; outstanding returns to 0.
- Overflow: 9 requests, tags 0..8, no responses -> outstanding = 8, drop_count = 1; tag 8 never appears on the output.
- Round-robin and backpressure: entries 0, 2, 5 DONE together, out_ready held low 4 cycles -> out_* stable throughout, then grant order 0, 2, 5.
- Timeout: TIMEOUT = 15, request with no response -> record at cycle ≥16 with out_timeout = 1, latency 15. A later resp for that tag sets err_unmatched.
- Same-cycle collisions: req and resp both tag 3 with no prior PEND -> err_unmatched = 1, entry stays PEND. Second req tag 3 -> err_dup_tag = 1, drop_count = 1.
- Reset while out_valid = 1 with 4 PEND entries -> next cycle: out_valid = 0, outstanding = 0, all flags and counters cleared.
